// File: rtl/uart_pkg.sv
// Shared encodings for the buffered UART transmitter: parity modes and FSM state names.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  // Mode 2'b11 is deliberately treated as "no parity bit".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake into the UART transmit buffer.
interface uart_tx_fifo_if #(parameter int DATA_W = 8);
  // Strict valid/ready: tx_data is transferred on any rising clk edge where
  // tx_valid and tx_ready are both 1; tx_ready never depends on tx_valid.
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is always visible on pop_data.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty stay distinct.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first framing with optional parity and 1/2 stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 bus,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    dbg_state
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_PARITY = ST_PARITY;
  localparam logic [2:0] S_STOP   = ST_STOP;

  logic [2:0]        state;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        par_q;
  logic              stop_more;
  logic [DATA_W-1:0] shreg;
  logic [3:0]        bit_idx;
  logic              par_bit;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head;
  logic              pop;

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.tx_valid),
    .push_data (bus.tx_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bus.tx_ready = !fifo_full;
  assign dbg_state    = state;

  // A frame starts from IDLE, or straight out of the final stop bit so frames abut.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == S_IDLE) pop = 1'b1;
      else if (state == S_STOP && cnt == '0 && !stop_more) pop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      cnt       <= '0;
      div_q     <= '0;
      par_q     <= PAR_NONE;
      stop_more <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
      par_bit   <= 1'b0;
    end else if (pop) begin
      // Config is sampled only here so mid-frame changes wait for the next frame.
      shreg     <= head;
      div_q     <= cfg_div;
      cnt       <= cfg_div;
      par_q     <= cfg_parity;
      stop_more <= cfg_stop2;
      par_bit   <= (^head) ^ (cfg_parity == PAR_ODD);
      tx        <= 1'b0;
      busy      <= 1'b1;
      state     <= S_START;
    end else begin
      case (state)
        S_IDLE: ;
        S_START: begin
          if (cnt == '0) begin
            cnt     <= div_q;
            tx      <= shreg[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end else cnt <= cnt - DIV_W'(1);
        end
        S_DATA: begin
          if (cnt == '0) begin
            cnt <= div_q;
            if (bit_idx == 4'(DATA_W - 1)) begin
              if (parity_enabled(par_q)) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_idx <= bit_idx + 4'd1;
            end
          end else cnt <= cnt - DIV_W'(1);
        end
        S_PARITY: begin
          if (cnt == '0) begin
            cnt   <= div_q;
            tx    <= 1'b1;
            state <= S_STOP;
          end else cnt <= cnt - DIV_W'(1);
        end
        S_STOP: begin
          if (cnt == '0) begin
            if (stop_more) begin
              stop_more <= 1'b0;
              cnt       <= div_q;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else cnt <= cnt - DIV_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8-bit instance for framing/FIFO/reset and a 5-bit instance at minimum divisor.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_div;
  logic [15:0] div5;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;

  logic        tx, busy;
  logic [4:0]  fifo_level;
  logic [2:0]  dbg_state;
  logic        tx5, busy5;
  logic [4:0]  fifo_level5;
  logic [2:0]  dbg_state5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_W(8)) bus8 ();
  uart_tx_fifo_if #(.DATA_W(5)) bus5 ();

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus8),
    .cfg_div (cfg_div), .cfg_parity (cfg_parity), .cfg_stop2 (cfg_stop2),
    .tx (tx), .busy (busy), .fifo_level (fifo_level), .dbg_state (dbg_state)
  );

  uart_tx_fifo #(.DATA_W(5), .FIFO_DEPTH(16), .DIV_W(16)) dut5 (
    .clk (clk), .rst (rst), .bus (bus5),
    .cfg_div (div5), .cfg_parity (PAR_NONE), .cfg_stop2 (1'b0),
    .tx (tx5), .busy (busy5), .fifo_level (fifo_level5), .dbg_state (dbg_state5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push8(input logic [7:0] d);
    bus8.tx_valid = 1'b1;
    bus8.tx_data  = d;
    tick();
    bus8.tx_valid = 1'b0;
  endtask

  // Holds for n cycles expecting a constant line level with busy high.
  task automatic hold(input string tag, input logic val, input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_tx"}, tx, val);
      check({tag, "_busy"}, busy, 1'b1);
      if (i == 0) check({tag, "_state"}, dbg_state, st);
      tick();
    end
  endtask

  // Entered at the first cycle of the start bit (minus skip already elapsed);
  // returns at the first cycle after the last stop bit.
  task automatic run_frame(input logic [7:0] data, input logic par_en, input logic par,
                           input logic stop2, input int bit_cyc, input int skip,
                           input int chg_bit, input logic [15:0] chg_div);
    hold("start", 1'b0, ST_START, bit_cyc - skip);
    for (int i = 0; i < 8; i++) begin
      if (i == chg_bit) cfg_div = chg_div;
      hold($sformatf("data%0d", i), data[i], ST_DATA, bit_cyc);
    end
    if (par_en) hold("parity", par, ST_PARITY, bit_cyc);
    hold("stop", 1'b1, ST_STOP, stop2 ? 2 * bit_cyc : bit_cyc);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_tx"}, tx, 1'b1);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    logic [6:0] exp5;
    rst           = 1'b0;
    bus8.tx_valid = 1'b0;
    bus8.tx_data  = '0;
    bus5.tx_valid = 1'b0;
    bus5.tx_data  = '0;
    cfg_div       = 16'd9;
    div5          = 16'd1;
    cfg_parity    = PAR_NONE;
    cfg_stop2     = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_tx", tx, 1'b1);
    check("rst_ready", bus8.tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 5'd0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_tx5", tx5, 1'b1);
    rst = 1'b1;
    tick();

    // Basic frame: 0x6A, no parity, 1 stop, 10-cycle bits, 100 cycles busy
    push8(8'h6A);
    check("basic_level_push", fifo_level, 5'd1);
    check("basic_tx_before", tx, 1'b1);
    check("basic_busy_before", busy, 1'b0);
    tick();
    check("basic_level_pop", fifo_level, 5'd0);
    run_frame(8'h6A, 1'b0, 1'b0, 1'b0, 10, 0, -1, 16'd0);
    expect_idle("basic_end");

    // Even parity: 0x6A has four ones, parity bit 0
    cfg_parity = PAR_EVEN;
    push8(8'h6A);
    tick();
    run_frame(8'h6A, 1'b1, 1'b0, 1'b0, 10, 0, -1, 16'd0);
    expect_idle("even_end");

    // Odd parity: parity bit 1
    cfg_parity = PAR_ODD;
    push8(8'h6A);
    tick();
    run_frame(8'h6A, 1'b1, 1'b1, 1'b0, 10, 0, -1, 16'd0);
    expect_idle("odd_end");

    // Two stop bits with even parity: 12 bits x 10 = 120 cycles
    cfg_parity = PAR_EVEN;
    cfg_stop2  = 1'b1;
    push8(8'h6A);
    tick();
    run_frame(8'h6A, 1'b1, 1'b0, 1'b1, 10, 0, -1, 16'd0);
    expect_idle("stop2_end");
    cfg_parity = PAR_NONE;
    cfg_stop2  = 1'b0;

    // Mode 11 behaves as no parity
    cfg_parity = 2'b11;
    push8(8'hC3);
    tick();
    run_frame(8'hC3, 1'b0, 1'b0, 1'b0, 10, 0, -1, 16'd0);
    expect_idle("par11_end");
    cfg_parity = PAR_NONE;

    // Config change mid-frame: frame A keeps 10-cycle bits, queued B uses 5
    bus8.tx_valid = 1'b1;
    bus8.tx_data  = 8'h5C;
    tick();
    bus8.tx_data  = 8'hA3;
    tick();
    bus8.tx_valid = 1'b0;
    check("chg_level", fifo_level, 5'd1);
    run_frame(8'h5C, 1'b0, 1'b0, 1'b0, 10, 0, 3, 16'd4);
    check("chg_level_b_popped", fifo_level, 5'd0);
    run_frame(8'hA3, 1'b0, 1'b0, 1'b0, 5, 0, -1, 16'd0);
    expect_idle("chg_end");
    cfg_div = 16'd99;

    // FIFO full: 18 words back to back, word 1 popped at once, word 18 dropped
    bus8.tx_valid = 1'b1;
    for (int d = 1; d <= 18; d++) begin
      bus8.tx_data = 8'(d);
      tick();
      check($sformatf("full_level_w%0d", d), fifo_level, (d == 1) ? 1 : ((d - 1 > 16) ? 16 : d - 1));
      check($sformatf("full_ready_w%0d", d), bus8.tx_ready, (d >= 17) ? 1'b0 : 1'b1);
    end
    bus8.tx_valid = 1'b0;
    run_frame(8'd1, 1'b0, 1'b0, 1'b0, 100, 16, -1, 16'd0);
    check("full_ready_after_pop", bus8.tx_ready, 1'b1);
    for (int d = 2; d <= 17; d++) begin
      check($sformatf("full_level_f%0d", d), fifo_level, 17 - d);
      run_frame(8'(d), 1'b0, 1'b0, 1'b0, 100, 0, -1, 16'd0);
    end
    expect_idle("full_end");
    check("full_level_end", fifo_level, 5'd0);
    cfg_div = 16'd9;

    // Reset mid-frame with three words queued
    bus8.tx_valid = 1'b1;
    bus8.tx_data  = 8'h00;
    repeat (4) tick();
    bus8.tx_valid = 1'b0;
    repeat (50) tick();
    check("rmid_pre_state", dbg_state, ST_DATA);
    check("rmid_pre_tx", tx, 1'b0);
    check("rmid_pre_level", fifo_level, 5'd3);
    rst = 1'b0;
    #1;
    check("rmid_tx", tx, 1'b1);
    check("rmid_busy", busy, 1'b0);
    check("rmid_level", fifo_level, 5'd0);
    check("rmid_ready", bus8.tx_ready, 1'b1);
    check("rmid_state", dbg_state, ST_IDLE);
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 150; i++) begin
      check("rmid_after_tx", tx, 1'b1);
      check("rmid_after_busy", busy, 1'b0);
      tick();
    end
    check("rmid_after_level", fifo_level, 5'd0);

    // Minimum config: DATA_W=5, cfg_div=1, 0x15 -> 0,1,0,1,0,1,1 at 2 cycles each
    bus5.tx_valid = 1'b1;
    bus5.tx_data  = 5'h15;
    tick();
    bus5.tx_valid = 1'b0;
    check("min_level", fifo_level5, 5'd1);
    tick();
    exp5 = 7'b1101010;
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < 2; c++) begin
        check($sformatf("min_bit%0d_tx", b), tx5, exp5[b]);
        check($sformatf("min_bit%0d_busy", b), busy5, 1'b1);
        tick();
      end
    end
    check("min_end_busy", busy5, 1'b0);
    check("min_end_tx", tx5, 1'b1);
    check("min_end_state", dbg_state5, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter for the SoC's serial console and debug path. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB first. Data width, bit period, parity and stop-bit count are configurable. Frames go back to back with no idle gap while the FIFO holds data.

## Interface

Parameters:
- DATA_W, default 8: data bits per frame, 5..9.
- FIFO_DEPTH, default 16: buffer words; power of two, at least 2.
- DIV_W, default 16: width of the bit-period divisor.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- tx_valid  in  1  write request.
- tx_data  in  DATA_W  word to send.
- tx_ready  out  1  FIFO not full; a word is accepted on a clock edge where tx_valid and tx_ready are both 1.
- cfg_div  in  DIV_W  bit period minus one, in cycles; must be at least 1.
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- cfg_stop2  in  1  1 selects two stop bits.
- tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words held.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- Reset values: tx=1, tx_ready=1, busy=0, fifo_level=0, state IDLE, FIFO flushed.
- Reset mid-frame: tx returns to 1 asynchronously. The partial frame and all buffered words are discarded.
- IDLE → START when the FIFO is non-empty. On that edge the block:
  - pops the head word into the shift register;
  - latches cfg_div, cfg_parity and cfg_stop2 for the whole frame;
  - drives tx=0 and sets busy=1.
- START → DATA after one bit period.
- DATA sends DATA_W bits, LSB first, one bit period each.
- DATA → PARITY if the latched parity mode is even or odd; otherwise DATA → STOP.
- Parity bit: even = XOR of the data bits; odd = its inverse.
- STOP drives tx=1 for one or two bit periods.
- At the end of STOP:
  - FIFO non-empty: go directly to START, popping on the same edge (no idle cycle);
  - FIFO empty: go to IDLE and clear busy.
- Config inputs that change mid-frame have no effect until the next frame starts.
- tx_ready = (fifo_level != FIFO_DEPTH), combinational from registered level. A push while full is ignored.
- A simultaneous push and pop leaves fifo_level unchanged. A push while full is never accepted, even on a pop edge.
- The bit counter counts down from the latched cfg_div to 0 and reloads on each bit boundary.

## Timing

- Bit period = cfg_div+1 cycles.
- Frame length = (1 + DATA_W + P + S) × (cfg_div+1) cycles, where P = 1 with parity, else 0, and S = number of stop bits.
- A push at edge k into an empty FIFO while IDLE gives tx=0 from edge k+1.
- fifo_level increments at edge k and decrements at k+1.
- tx and busy are registered outputs with no combinational path from the inputs.
- busy falls on the edge that ends the last stop bit of the last buffered frame.

## Structure

- Package uart_pkg holds:
  - the parity encodings PAR_NONE, PAR_EVEN, PAR_ODD;
  - the state enum uart_tx_state_t.
- Sub-module uart_fifo: a synchronous FIFO parametrised by width and depth.
  - Outputs: full, empty, level.
  - Read data is valid at the head, first-word fall-through.
  - The transmitter FSM and shift/parity logic stay in uart_tx_fifo.

## Test plan

- **Basic frame.** Reset; cfg_div=9, parity none, 1 stop; push 0x6A.
  - tx low for 10 cycles, then 0,1,0,1,0,1,1,0 at 10 cycles each, then high for 10 cycles.
  - busy high for exactly 100 cycles.
- **Parity and stop bits.** Push 0x6A with even parity: parity bit 0. With odd parity: parity bit 1. With cfg_stop2=1: stop high for 20 cycles; frame length 120 cycles.
- **FIFO full.** cfg_div=99; push 18 words back to back (1, then 2..18).
  - Word 1 popped; fifo_level reaches 16; tx_ready=0; word 18 dropped.
  - Words 1..17 transmitted in order with no idle gap between frames.
- **Config change mid-frame.** Change cfg_div from 9 to 4 during DATA.
  - Current frame keeps 10-cycle bits; next queued frame uses 5-cycle bits.
- **Reset mid-frame.** Drive rst=0 mid-DATA with 3 words queued.
  - tx=1 immediately; fifo_level=0; busy=0; no further frames after rst=1.
- **Minimum config.** DATA_W=5 instance, cfg_div=1.
  - Push 0x15: 2-cycle bits, data 1,0,1,0,1, frame length 14 cycles.
